// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StFix  = 2'd3
  } state_e;

  localparam int unsigned ITER = 32;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor when it fits.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = (shifted >= {1'b0, divisor_i});
    // A zero divisor always "fits", so the remainder ends up holding the dividend itself.
    rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: 32-cycle shift-add multiply,
// 32-cycle restoring divide, then one sign-fix cycle that commits HI/LO.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             rd_sel_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 negr_q, negr_d;
  logic                 is_div_q, is_div_d;
  logic                 done_q, done_d;

  logic                 signed_op;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     div_rem, div_quo;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 last_iter;

  // For division, acc holds {partial remainder, dividend/quotient}.
  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i    (acc_q[WIDTH-1:0]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem),
    .quo_o    (div_quo)
  );

  always_comb begin
    signed_op = (op_i == OpMult) || (op_i == OpDiv);
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;

    // For multiply, acc holds {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    last_iter = (cnt_q == CNT_W'(ITER - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;

    if (flush_i) begin
      // Cancels any in-flight work; in idle it also swallows a coincident start.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            case (op_i)
              OpMult, OpMultu: begin
                state_d  = StMul;
                cnt_d    = '0;
                acc_d    = {{WIDTH{1'b0}}, b_mag};
                opnd_d   = a_mag;
                neg_d    = a_neg ^ b_neg;
                negr_d   = 1'b0;
                is_div_d = 1'b0;
              end
              OpDiv, OpDivu: begin
                state_d  = StDiv;
                cnt_d    = '0;
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                opnd_d   = b_mag;
                neg_d    = a_neg ^ b_neg;
                negr_d   = a_neg;
                is_div_d = 1'b1;
              end
              OpMthi:  hi_d = a_i;
              OpMtlo:  lo_d = a_i;
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = StFix;
        end
        StDiv: begin
          acc_d = {div_rem, div_quo};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) state_d = StFix;
        end
        StFix: begin
          if (is_div_q) begin
            // Divide by zero: all-ones quotient, HI keeps the original dividend.
            lo_d = (opnd_q == '0) ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
          state_d = StIdle;
          done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign rdata_o = rd_sel_i ? hi_q : lo_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus randomized MUL/DIV traffic
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = OpNop;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rdata, hi, lo;
  logic        busy, done;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu_iterative dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .rd_sel_i(rd_sel),
    .rdata_o (rdata),
    .hi_o    (hi),
    .lo_o    (lo),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference result {hi, lo} from MIPS semantics with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      p;
    int          q, r;
    logic [63:0] res;
    res = '0;
    case (o)
      OpMult: begin
        p   = longint'($signed(x)) * longint'($signed(y));
        res = p;
      end
      OpMultu: res = {32'b0, x} * {32'b0, y};
      OpDiv: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q   = $signed(x) / $signed(y);
          r   = $signed(x) % $signed(y);
          res = {r, q};
        end
      end
      OpDivu: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OpNop;
  endtask

  task automatic run_muldiv(input string tag, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y);
    logic [63:0] r;
    int          lat, busy_n;
    bit          seen;
    r = ref_result(o, x, y);
    issue(o, x, y);
    busy_n = busy ? 1 : 0;
    lat    = 0;
    seen   = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else if (busy) begin
        busy_n++;
      end
    end
    hi_m = r[63:32];
    lo_m = r[31:0];
    check({tag, ".latency"}, lat, 33);
    check({tag, ".busy_cycles"}, busy_n, 33);
    check({tag, ".busy_in_done"}, busy, 0);
    check({tag, ".hi"}, hi, hi_m);
    check({tag, ".lo"}, lo, lo_m);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          done_seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_muldiv("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("multu_max.done_one_cycle", done, 0);
    run_muldiv("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5);
    run_muldiv("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2);
    run_muldiv("divu_by0", OpDivu, 32'd100, 32'd0);
    run_muldiv("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    run_muldiv("div_by0", OpDiv, 32'hFFFF_FF9C, 32'd0);

    // MTHI / MTLO commit on the accepting edge, no busy/done
    issue(OpMthi, 32'h1234_5678, 32'h0);
    hi_m = 32'h1234_5678;
    check("mthi.hi", hi, hi_m);
    check("mthi.busy", busy, 0);
    check("mthi.done", done, 0);
    issue(OpMtlo, 32'h9ABC_DEF0, 32'h0);
    lo_m = 32'h9ABC_DEF0;
    check("mtlo.lo", lo, lo_m);
    check("mtlo.busy", busy, 0);
    rd_sel = 1'b1;
    #1;
    check("rdata.hi", rdata, hi_m);
    rd_sel = 1'b0;
    #1;
    check("rdata.lo", rdata, lo_m);
    @(posedge clk);
    #1;
    check("mtlo.done_after", done, 0);

    // MULTU with a start during busy (cycle 5) and a flush on cycle 10
    issue(OpMultu, 32'd7, 32'd9);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(OpMthi, 32'hDEAD_BEEF, 32'h0);
    check("busy_start.busy", busy, 1);
    check("busy_start.hi", hi, hi_m);
    rd_sel = 1'b1;
    #1;
    check("busy_rdata.hi", rdata, hi_m);
    rd_sel = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.busy", busy, 0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("flush.no_done", done_seen, 0);
    check("flush.hi", hi, hi_m);
    check("flush.lo", lo, lo_m);

    // flush and start on the same idle edge: start dropped
    flush = 1'b1;
    issue(OpMultu, 32'd3, 32'd3);
    flush = 1'b0;
    check("flush_start.busy", busy, 0);
    check("flush_start.lo", lo, lo_m);

    // Asynchronous reset mid-DIV
    issue(OpDiv, 32'd1000, 32'd3);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    hi_m = '0;
    lo_m = '0;
    check("async_rst.hi", hi, hi_m);
    check("async_rst.lo", lo, lo_m);
    check("async_rst.busy", busy, 0);
    check("async_rst.done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_muldiv("divu_100_7", OpDivu, 32'd100, 32'd7);

    // Randomized MUL/DIV traffic
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(1, 4));
      rx = $urandom;
      case ($urandom_range(0, 9))
        0:       ry = 32'd0;
        1: begin
          rx = 32'h8000_0000;
          ry = 32'hFFFF_FFFF;
        end
        2:       ry = 32'($urandom_range(1, 15));
        3:       ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ry = $urandom;
      endcase
      run_muldiv($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- Sits directly upstream of the 32-bit 4:1 write-back select mux: its rdata output drives that mux's A3 input for MFHI/MFLO.
- The control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is verified.
- CNT_W, 6, iteration-counter width. Must hold WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation in op. Sampled on the rising edge.
- op  input  3  operation code, from the shared package constants.
- a  input  32  rs operand; dividend/multiplicand. Captured when start is accepted.
- b  input  32  rt operand; divisor/multiplier. Captured when start is accepted.
- flush  input  1  synchronous cancel of an in-flight MUL/DIV.
- rd_sel  input  1  0 selects LO, 1 selects HI on rdata.
- rdata  output  32  combinational read of the register selected by rd_sel.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  high while an iterative operation is in flight.
- done  output  1  one-cycle pulse when a MUL/DIV result commits.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, counter=0, busy=0, done=0, operand registers=0. An in-flight result is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with op=MULT/MULTU: go to MUL. Operands captured as magnitudes for signed ops; result sign = a[31]^b[31].
  - start with op=DIV/DIVU: go to DIV. Quotient sign = a[31]^b[31]; remainder sign = a[31].
  - start with op=MTHI: hi<=a on the same edge, stay IDLE, no busy, no done. MTLO is the same with lo.
  - start with op=NOP or an undefined code: ignored.
- MUL: radix-2 shift-add, one bit per cycle, 32 cycles, 64-bit product accumulator.
- DIV: restoring division, one quotient bit per cycle, 32 cycles.
- After 32 iterations: go to FIX. FIX applies two's-complement sign correction, writes hi/lo, and goes to IDLE. done=1 for exactly the cycle after the commit edge.
- Latency: start accepted on edge E0; hi/lo update on edge E33; done high between E33 and E34.
- busy: high from after E0 until E33. Low in the done cycle. A new start is legal in the done cycle.
- Boundary conditions:
  - start while busy: ignored, including MTHI/MTLO. The CPU stall guarantees this does not happen; the bench still checks it.
  - flush while busy: state goes to IDLE on the next edge; hi/lo are not modified; no done.
  - flush in IDLE: no effect. flush and start on the same edge in IDLE: flush wins and start is dropped.
  - Divide by zero (DIV or DIVU): same 33-cycle latency; lo=32'hFFFF_FFFF, hi=a.
  - Signed overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
  - Unsigned and signed results are exact 64-bit products. The quotient truncates toward zero.
- rdata: rd_sel ? hi : lo, combinational. During busy it returns the pre-operation values.

Decomposition:
- Package mdu_pkg holds:
  - op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
  - state encodings: IDLE=0, MUL=1, DIV=2, FIX=3;
  - ITER=32.
- One sub-module, mdu_div_step: a combinational single restoring-division step taking {rem, quo, divisor} and returning {rem', quo'}.
- Multiplication stays inline.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; done exactly 33 edges after start; busy high 33 cycles.
- MULT a=-3 (FFFF_FFFD), b=5 -> hi=FFFF_FFFF, lo=FFFF_FFF1. Then DIV a=-7, b=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF.
- DIVU a=100, b=0 -> lo=FFFF_FFFF, hi=0000_0064. DIV a=8000_0000, b=FFFF_FFFF -> lo=8000_0000, hi=0.
- MTHI a=1234_5678, then MTLO a=9ABC_DEF0 -> each committed on the accepting edge; rdata follows rd_sel (1 gives 1234_5678, 0 gives 9ABC_DEF0); busy and done stay 0.
- Start MULTU 7x9, then assert flush on cycle 10 -> busy falls next edge, no done, hi/lo keep prior values. A start during busy (cycle 5) is ignored.
- Assert rst asynchronously mid-DIV (cycle 20) -> hi=lo=0, busy=done=0 immediately. After release, DIVU 100/7 -> lo=14, hi=2.
